tap_loader: RTL and testbench

Coefficient writer for the FIR filter's tap-load port. Holds a host-writable bank of tap values and, on an active-low start request, replays the whole bank into the filter as a burst of one-cycle `o_tap_wr` strobes. It sits between the host/config side and the filter's `i_tap_wr`/`i_tap` inputs. While a load is in progress it gates the filter's sample clock enable so no samples are processed against a half-loaded tap set.

---
 rtl/filter_pkg.sv | 14 +
 rtl/tap_loader_if.sv | 32 +++
 rtl/tap_bank.sv | 33 +++
 rtl/tap_loader.sv | 104 ++++++++++
 tb/tb_tap_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared FIR filter definitions: tap word width, tap type and the loader state encoding.
package filter_pkg;

    localparam int TW = 16;

    typedef logic [TW-1:0] tap_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/tap_loader_if.sv
// Host tap-write bus plus the tap-load port into the filter, as seen by the loader.
interface tap_loader_if
    import filter_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int TW    = filter_pkg::TW,
    parameter int AW    = $clog2(NTAPS)
);

    logic          i_host_wr;
    logic [AW-1:0] i_host_addr;
    logic [TW-1:0] i_host_data;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;

    modport slave (
        input  i_host_wr,
        input  i_host_addr,
        input  i_host_data,
        output o_tap_wr,
        output o_tap
    );

    modport master (
        output i_host_wr,
        output i_host_addr,
        output i_host_data,
        input  o_tap_wr,
        input  o_tap
    );

endinterface

// File: rtl/tap_bank.sv
// Host-writable tap register file with a combinational read port.
module tap_bank
    import filter_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int TW    = filter_pkg::TW,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [TW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [TW-1:0] o_rd_data
);

    logic [TW-1:0] r_bank [NTAPS];

    // Addresses past the last tap are silently ignored when NTAPS is not a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_wr_en && (int'(i_wr_addr) < NTAPS)) begin
            r_bank[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = (int'(i_rd_addr) < NTAPS) ? r_bank[i_rd_addr] : '0;

endmodule

// File: rtl/tap_loader.sv
// Replays the tap bank into the filter, highest index first, on a falling edge of i_start.
module tap_loader
    import filter_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int TW    = filter_pkg::TW,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic         i_start,
    tap_loader_if.slave  bus,
    output logic         o_ce,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [1:0]    ST_IDLE  = IDLE;
    localparam logic [1:0]    ST_LOAD  = LOAD;
    localparam logic [1:0]    ST_DONE  = DONE;
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_idx;
    logic          r_last;
    logic          r_start_q;
    logic          r_tap_wr;
    logic [TW-1:0] r_tap;
    logic          r_done;

    logic          w_req;
    logic          w_bank_wr;
    logic [TW-1:0] w_rd_data;

    assign w_req     = r_start_q & ~i_start;
    assign w_bank_wr = bus.i_host_wr & (r_state == ST_IDLE);

    tap_bank #(
        .NTAPS (NTAPS),
        .TW    (TW),
        .AW    (AW)
    ) u_bank (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (w_bank_wr),
        .i_wr_addr (bus.i_host_addr),
        .i_wr_data (bus.i_host_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    // r_last marks that index 0 has gone out, so LOAD spends one extra cycle before DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_start_q <= 1'b1;
            r_tap_wr  <= 1'b0;
            r_tap     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_tap_wr  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_LOAD;
                        r_idx   <= LAST_IDX;
                        r_last  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (r_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_tap    <= w_rd_data;
                        r_tap_wr <= 1'b1;
                        r_last   <= (r_idx == '0);
                        if (r_idx != '0) begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_ce         = i_ce & ~o_busy;
    assign o_done       = r_done;
    assign bus.o_tap_wr = r_tap_wr;
    assign bus.o_tap    = r_tap;

endmodule

// File: tb/tb_tap_loader.sv
// Scoreboard bench for tap_loader: an 8-tap instance for timing/collisions and a 6-tap one for out-of-range writes.
module tb_tap_loader;
    import filter_pkg::*;

    typedef struct {
        int   cyc;
        tap_t val;
    } expTap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iCe = 1'b1;
    logic startN = 1'b1;
    logic startNB = 1'b1;
    logic ceA, busyA, doneA;
    logic ceB, busyB, doneB;

    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;
    int doneCountB = 0;

    expTap_t tapQ[$];
    int      doneQ[$];
    tap_t    tapQB[$];
    tap_t    modelBank[8];
    tap_t    modelBankB[6];

    tap_loader_if #(.NTAPS(8)) busA();
    tap_loader_if #(.NTAPS(6)) busB();

    tap_loader #(.NTAPS(8)) dutA (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (iCe),
        .i_start (startN),
        .bus     (busA),
        .o_ce    (ceA),
        .o_busy  (busyA),
        .o_done  (doneA)
    );

    tap_loader #(.NTAPS(6)) dutB (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (iCe),
        .i_start (startNB),
        .bus     (busB),
        .o_ce    (ceB),
        .o_busy  (busyB),
        .o_done  (doneB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Every strobe and done pulse must match the head of its queue in value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (busA.o_tap_wr) begin
                if (tapQ.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    expTap_t e;
                    e = tapQ.pop_front();
                    checkOutput("tap_value", 32'(busA.o_tap), 32'(e.val));
                    checkOutput("tap_cycle", cyc, e.cyc);
                end
            end
            if (doneA) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    checkOutput("done_cycle", cyc, doneQ.pop_front());
                end
            end
            if (busB.o_tap_wr) begin
                if (tapQB.size() == 0) begin
                    checkOutput("unexpected_strobe_b", 32'd1, 32'd0);
                end else begin
                    checkOutput("tap_value_b", 32'(busB.o_tap), 32'(tapQB.pop_front()));
                end
            end
            if (doneB) doneCountB++;
        end
    end

    task automatic pushBurst(input int k, input int nPush, input bit withDone);
        for (int j = 0; j < nPush; j++) begin
            tapQ.push_back('{k + 1 + j, modelBank[7 - j]});
        end
        if (withDone) doneQ.push_back(k + 9);
    endtask

    task automatic hostWriteA(input int addr, input tap_t data);
        @(negedge clk);
        busA.i_host_wr   = 1'b1;
        busA.i_host_addr = 3'(addr);
        busA.i_host_data = data;
        modelBank[addr]  = data;
        @(negedge clk);
        busA.i_host_wr = 1'b0;
    endtask

    task automatic hostWriteB(input int addr, input tap_t data);
        @(negedge clk);
        busB.i_host_wr   = 1'b1;
        busB.i_host_addr = 3'(addr);
        busB.i_host_data = data;
        if (addr < 6) modelBankB[addr] = data;
        @(negedge clk);
        busB.i_host_wr = 1'b0;
    endtask

    // One request on DUT A, with optional same-cycle write, mid-burst write or retrigger, and a long low hold.
    task automatic applyStimulus(input bit reqWrite, input int reqAddr, input tap_t reqData,
                                 input bit midWrite, input bit midRetrigger, input int holdLow);
        int   k;
        int   nCycles;
        logic expBusy;
        @(negedge clk);
        startN = 1'b0;
        if (reqWrite) begin
            busA.i_host_wr     = 1'b1;
            busA.i_host_addr   = 3'(reqAddr);
            busA.i_host_data   = reqData;
            modelBank[reqAddr] = reqData;
        end
        k = cyc + 1;
        pushBurst(k, 8, 1'b1);
        nCycles = (holdLow + 2 > 13) ? holdLow + 2 : 13;
        for (int n = 0; n < nCycles; n++) begin
            @(negedge clk);
            busA.i_host_wr = 1'b0;
            startN = (n < holdLow) ? 1'b0 : 1'b1;
            if (midRetrigger && n == 3) startN = 1'b0;
            if (midWrite && n == 3) begin
                busA.i_host_wr   = 1'b1;
                busA.i_host_addr = 3'd3;
                busA.i_host_data = 16'hBEEF;
            end
            iCe = 1'($urandom_range(0, 1));
            #1;
            expBusy = (cyc >= k) && (cyc <= k + 9);
            checkOutput("o_busy", 32'(busyA), 32'(expBusy));
            checkOutput("o_ce", 32'(ceA), 32'(iCe & ~expBusy));
        end
        busA.i_host_wr = 1'b0;
        startN = 1'b1;
        checkOutput("tapq_drained", tapQ.size(), 0);
        checkOutput("doneq_drained", doneQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        busA.i_host_wr = 1'b0; busA.i_host_addr = '0; busA.i_host_data = '0;
        busB.i_host_wr = 1'b0; busB.i_host_addr = '0; busB.i_host_data = '0;
        for (int i = 0; i < 8; i++) modelBank[i] = '0;
        for (int i = 0; i < 6; i++) modelBankB[i] = '0;

        $display("[TB] reset defaults");
        rst = 1'b1;
        startN = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        startN = 1'b1;
        #1;
        checkOutput("rst_tap_wr", 32'(busA.o_tap_wr), 0);
        checkOutput("rst_tap", 32'(busA.o_tap), 0);
        checkOutput("rst_busy", 32'(busyA), 0);
        checkOutput("rst_done", 32'(doneA), 0);
        checkOutput("rst_ce", 32'(ceA), 1);
        repeat (5) @(negedge clk);
        checkOutput("idle_busy", 32'(busyA), 0);

        $display("[TB] basic load with ce gating");
        for (int i = 0; i < 8; i++) hostWriteA(i, tap_t'(16'h0100 + i));
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, 0);
        checkOutput("tap_hold", 32'(busA.o_tap), 32'h0100);
        checkOutput("tap_wr_low", 32'(busA.o_tap_wr), 0);

        $display("[TB] write collisions");
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 7, 16'hCAFE, 1'b0, 1'b0, 0);

        $display("[TB] retrigger");
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, 20);
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b1, 0);

        $display("[TB] reset mid-load");
        @(negedge clk);
        startN = 1'b0;
        k = cyc + 1;
        pushBurst(k, 4, 1'b0);
        @(negedge clk);
        startN = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_tap_wr", 32'(busA.o_tap_wr), 0);
        checkOutput("midrst_busy", 32'(busyA), 0);
        checkOutput("midrst_done", 32'(doneA), 0);
        checkOutput("midrst_tap", 32'(busA.o_tap), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) modelBank[i] = '0;
        for (int i = 0; i < 6; i++) modelBankB[i] = '0;
        repeat (14) @(negedge clk);
        checkOutput("midrst_tapq_drained", tapQ.size(), 0);
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, 0);

        $display("[TB] out-of-range host writes, 6 taps");
        for (int i = 0; i < 6; i++) hostWriteB(i, tap_t'(16'h0A00 + i));
        hostWriteB(6, 16'hDEAD);
        hostWriteB(7, 16'hDEAD);
        @(negedge clk);
        startNB = 1'b0;
        for (int j = 5; j >= 0; j--) tapQB.push_back(modelBankB[j]);
        @(negedge clk);
        startNB = 1'b1;
        repeat (14) @(negedge clk);
        checkOutput("tapqb_drained", tapQB.size(), 0);
        checkOutput("done_count_b", doneCountB, 1);
        checkOutput("busy_b_idle", 32'(busyB), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
